// File: rtl/conv3x3_pe_pkg.sv
// Shared constants for the 3x3 convolution PE: tap geometry, loader state
// encodings and the accumulator minimum-width rule.
package conv3x3_pe_pkg;

  localparam int NROWS  = 3;
  localparam int NCOLS  = 3;
  localparam int NTAPS  = NROWS * NCOLS;
  localparam int WIDX_W = 4;
  localparam int STAGES = 4;

  localparam logic [0:0] LD_LOAD  = 1'b0;
  localparam logic [0:0] LD_READY = 1'b1;

  // Nine products of w+ww bits need 4 guard bits to sum without overflow.
  function automatic int acc_min_width(input int w, input int ww);
    return w + ww + 4;
  endfunction

endpackage

// File: rtl/conv3x3_wload.sv
// Serial weight loader: nine-entry weight file plus the LOAD/READY FSM that
// raises weights_ok once every tap has been written.
module conv3x3_wload
  import conv3x3_pe_pkg::*;
#(
  parameter int WWIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           w_clr,
  input  logic                           w_valid,
  input  logic [WWIDTH-1:0]              w_in,
  output logic                           weights_ok,
  output logic [NTAPS-1:0][WWIDTH-1:0]   w_taps
);

  logic [0:0]                     state_q, state_d;
  logic [WIDX_W-1:0]              w_idx_q, w_idx_d;
  logic                           ok_q, ok_d;
  logic [NTAPS-1:0][WWIDTH-1:0]   w_q, w_d;

  always_comb begin
    state_d = state_q;
    w_idx_d = w_idx_q;
    ok_d    = ok_q;
    w_d     = w_q;
    if (w_clr) begin
      state_d = LD_LOAD;
      w_idx_d = '0;
      ok_d    = 1'b0;
    end else if (w_valid) begin
      if (state_q == LD_READY) begin
        // A write in READY restarts a full reload from tap 0.
        w_d[0]  = w_in;
        w_idx_d = WIDX_W'(1);
        ok_d    = 1'b0;
        state_d = LD_LOAD;
      end else begin
        for (int k = 0; k < NTAPS; k++)
          if (w_idx_q == WIDX_W'(k)) w_d[k] = w_in;
        if (w_idx_q == WIDX_W'(NTAPS - 1)) begin
          state_d = LD_READY;
          ok_d    = 1'b1;
          w_idx_d = '0;
        end else begin
          w_idx_d = w_idx_q + WIDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LD_LOAD;
      w_idx_q <= '0;
      ok_q    <= 1'b0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      w_idx_q <= w_idx_d;
      ok_q    <= ok_d;
      w_q     <= w_d;
    end
  end

  assign weights_ok = ok_q;
  assign w_taps     = w_q;

endmodule

// File: rtl/conv3x3_pe.sv
// Four-stage 3x3 convolution PE: per-tap multiply, row sums, bias add,
// optional ReLU. One window per cycle; hold freezes every stage.
module conv3x3_pe
  import conv3x3_pe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int WWIDTH    = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_clr,
  input  logic                   w_valid,
  input  logic [WWIDTH-1:0]      w_in,
  output logic                   weights_ok,
  input  logic                   win_valid,
  input  logic [WIDTH*3-1:0]     win2,
  input  logic [WIDTH*3-1:0]     win1,
  input  logic [WIDTH*3-1:0]     win0,
  input  logic [ACC_WIDTH-1:0]   bias,
  input  logic                   relu_en,
  input  logic                   hold,
  output logic                   out_valid,
  output logic [ACC_WIDTH-1:0]   out,
  output logic [15:0]            out_cnt,
  output logic                   drop
);

  localparam int PW = WIDTH + WWIDTH;
  localparam int RW = PW + 2;

  if (ACC_WIDTH < acc_min_width(WIDTH, WWIDTH)) begin : g_acc_too_narrow
    $error("conv3x3_pe: ACC_WIDTH too narrow for WIDTH+WWIDTH+4");
  end

  typedef struct packed {
    logic                     relu;
    logic [NTAPS-1:0][PW-1:0] prod;
  } s1_t;

  typedef struct packed {
    logic                     relu;
    logic [NROWS-1:0][RW-1:0] row;
  } s2_t;

  typedef struct packed {
    logic                     relu;
    logic [ACC_WIDTH-1:0]     sum;
  } s3_t;

  logic [NTAPS-1:0][WWIDTH-1:0]      w_taps;
  logic [NROWS-1:0][NCOLS*WIDTH-1:0] rows;
  logic [NTAPS-1:0][WIDTH-1:0]       pix;
  logic [NTAPS-1:0][PW-1:0]          prod;

  conv3x3_wload #(.WWIDTH(WWIDTH)) u_wload (
    .clk        (clk),
    .rst        (rst),
    .w_clr      (w_clr),
    .w_valid    (w_valid),
    .w_in       (w_in),
    .weights_ok (weights_ok),
    .w_taps     (w_taps)
  );

  assign rows = {win2, win1, win0};

  for (genvar r = 0; r < NROWS; r++) begin : g_row
    for (genvar c = 0; c < NCOLS; c++) begin : g_col
      assign pix[NCOLS*r+c]  = rows[r][WIDTH*c +: WIDTH];
      assign prod[NCOLS*r+c] = PW'($signed(pix[NCOLS*r+c])) *
                               PW'($signed(w_taps[NCOLS*r+c]));
    end
  end

  logic              accept;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES:1]   vld_q, vld_d;
  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  s3_t               s3_q, s3_d;
  logic [ACC_WIDTH-1:0] out_q, out_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              drop_q, drop_d;

  assign accept   = win_valid & weights_ok & ~hold;
  assign vld_pipe = {vld_q, accept};

  always_comb begin
    vld_d  = vld_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    s3_d   = s3_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
    drop_d = drop_q | (win_valid & ~weights_ok & ~hold);
    if (!hold) begin
      vld_d = vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) begin
        s1_d.relu = relu_en;
        s1_d.prod = prod;
      end
      if (vld_pipe[1]) begin
        s2_d.relu = s1_q.relu;
        for (int r = 0; r < NROWS; r++)
          s2_d.row[r] = RW'($signed(s1_q.prod[NCOLS*r]))   +
                        RW'($signed(s1_q.prod[NCOLS*r+1])) +
                        RW'($signed(s1_q.prod[NCOLS*r+2]));
      end
      if (vld_pipe[2]) begin
        s3_d.relu = s2_q.relu;
        s3_d.sum  = ACC_WIDTH'($signed(s2_q.row[0])) +
                    ACC_WIDTH'($signed(s2_q.row[1])) +
                    ACC_WIDTH'($signed(s2_q.row[2])) + bias;
      end
      if (vld_pipe[3]) begin
        out_d = (s3_q.relu && s3_q.sum[ACC_WIDTH-1]) ? '0 : s3_q.sum;
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  assign out_valid = vld_q[STAGES];
  assign out       = out_q;
  assign out_cnt   = cnt_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_conv3x3_pe.sv
// Scoreboard bench for conv3x3_pe: a plain-arithmetic model predicts each
// accepted window's result; a monitor pops and compares on every new output.
module tb_conv3x3_pe;

  localparam int W  = 8;
  localparam int WW = 8;
  localparam int AW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b0, w_clr = 1'b0, w_valid = 1'b0;
  logic            win_valid = 1'b0, relu_en = 1'b0, hold = 1'b0;
  logic [WW-1:0]   w_in = '0;
  logic [3*W-1:0]  win2 = '0, win1 = '0, win0 = '0;
  logic [AW-1:0]   bias = '0;
  logic            weights_ok, out_valid, drop;
  logic [AW-1:0]   out;
  logic [15:0]     out_cnt;

  conv3x3_pe #(.WIDTH(W), .WWIDTH(WW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .w_clr(w_clr), .w_valid(w_valid), .w_in(w_in),
    .weights_ok(weights_ok), .win_valid(win_valid), .win2(win2), .win1(win1),
    .win0(win0), .bias(bias), .relu_en(relu_en), .hold(hold),
    .out_valid(out_valid), .out(out), .out_cnt(out_cnt), .drop(drop)
  );

  int errors = 0, checks = 0, n_out = 0;
  int wm[9];
  int wsrc[9];
  int px[9];
  bit ok_m = 1'b0, drop_m = 1'b0;
  int idx_m = 0;
  longint exp_q[$];
  bit adv_q = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Result of the current window under the model's weights: dot product plus
  // bias, reduced modulo 2^AW, optionally clamped at zero.
  function automatic longint expect_result();
    longint s;
    logic signed [AW-1:0] r;
    s = longint'($signed(bias));
    for (int k = 0; k < 9; k++) s += longint'(px[k]) * longint'(wm[k]);
    r = s[AW-1:0];
    if (relu_en && r < 0) r = '0;
    return longint'(r);
  endfunction

  task automatic model_edge();
    if (win_valid && !hold) begin
      if (ok_m) exp_q.push_back(expect_result());
      else drop_m = 1'b1;
    end
    if (w_clr) begin
      idx_m = 0;
      ok_m  = 1'b0;
    end else if (w_valid) begin
      if (ok_m) begin
        wm[0] = int'($signed(w_in));
        idx_m = 1;
        ok_m  = 1'b0;
      end else begin
        wm[idx_m] = int'($signed(w_in));
        if (idx_m == 8) begin
          ok_m  = 1'b1;
          idx_m = 0;
        end else idx_m++;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 9; k++) wm[k] = 0;
    ok_m = 1'b0; drop_m = 1'b0; idx_m = 0; n_out = 0;
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    w_valid = 1'b0; w_clr = 1'b0; win_valid = 1'b0;
  endtask

  task automatic drive_win();
    win0 = {px[2][7:0], px[1][7:0], px[0][7:0]};
    win1 = {px[5][7:0], px[4][7:0], px[3][7:0]};
    win2 = {px[8][7:0], px[7][7:0], px[6][7:0]};
    win_valid = 1'b1;
  endtask

  task automatic rand_px();
    for (int k = 0; k < 9; k++) px[k] = int'($urandom_range(255)) - 128;
  endtask

  task automatic load_n(input int n);
    w_clr = 1'b1; tick();
    for (int k = 0; k < n; k++) begin
      w_in = 8'(wsrc[k]); w_valid = 1'b1; tick();
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    hold = 1'b0;
    while (exp_q.size() > 0 && b < 40) begin tick(); b++; end
    chk("drain_empty", longint'(exp_q.size()), 0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // A new output exists when out_valid is high after an edge that advanced.
  always @(posedge clk) adv_q <= !hold;

  always @(negedge clk) begin : monitor
    longint e;
    if (rst && adv_q && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got %0d, expected no output", $signed(out));
      end else begin
        e = exp_q.pop_front();
        chk("result", longint'($signed(out)), e);
      end
      n_out++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_weights_ok", weights_ok, 0);
    chk("rst_drop", drop, 0);
    chk("rst_out", out, 0);
    rst = 1'b1;

    // All-ones weights, window 1..9: exact latency and value 45.
    for (int k = 0; k < 9; k++) wsrc[k] = 1;
    load_n(9);
    chk("ok_after_9", weights_ok, 1);
    bias = '0; relu_en = 1'b0;
    for (int k = 0; k < 9; k++) px[k] = k + 1;
    drive_win(); tick();
    chk("lat_s1", out_valid, 0); tick();
    chk("lat_s2", out_valid, 0); tick();
    chk("lat_s3", out_valid, 0); tick();
    chk("lat_s4", out_valid, 1);
    chk("out_45", longint'($signed(out)), 45);
    chk("cnt_1", out_cnt, 1);
    drain();

    // Negative weights with bias, then with ReLU.
    for (int k = 0; k < 9; k++) wsrc[k] = -1;
    load_n(9);
    bias = 20'(5);
    drive_win(); tick(); drain();
    chk("out_m40", longint'($signed(out)), -40);
    relu_en = 1'b1;
    drive_win(); tick(); drain();
    chk("out_relu0", longint'($signed(out)), 0);
    relu_en = 1'b0;

    // Extreme operands, then bias pushes the sum past 2^19.
    for (int k = 0; k < 9; k++) begin wsrc[k] = -128; px[k] = -128; end
    load_n(9);
    bias = '0;
    drive_win(); tick(); drain();
    chk("out_max", longint'($signed(out)), 147456);
    bias = 20'(524287);
    drive_win(); tick(); drain();
    chk("out_wrap", longint'($signed(out)), -376833);
    bias = 20'(3);

    // Window after only 8 weights is dropped; 9th weight then enables it.
    for (int k = 0; k < 9; k++) wsrc[k] = 3;
    load_n(8);
    chk("ok_after_8", weights_ok, 0);
    rand_px(); drive_win(); tick();
    repeat (5) tick();
    chk("drop_set", drop, 1);
    chk("cnt_no_drop_out", out_cnt, longint'(n_out));
    w_in = 8'(3); w_valid = 1'b1; tick();
    chk("ok_after_9th", weights_ok, 1);
    drive_win(); tick(); drain();
    chk("drop_sticky", drop, 1);
    // Window on the same cycle as the 9th weight is dropped too.
    load_n(8);
    w_in = 8'(3); w_valid = 1'b1; rand_px(); drive_win(); tick();
    repeat (5) tick();
    chk("ok_same_cycle", weights_ok, 1);
    chk("cnt_same_cycle", out_cnt, longint'(n_out));

    // Six back-to-back windows with a 3-cycle hold mid-stream.
    do_reset();
    for (int k = 0; k < 9; k++) wsrc[k] = int'($urandom_range(255)) - 128;
    load_n(9);
    bias = 20'(int'($urandom_range(2000)) - 1000);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        hold = 1'b1;
        repeat (3) begin rand_px(); drive_win(); tick(); end
        hold = 1'b0;
      end
      rand_px(); drive_win(); tick();
    end
    drain();
    chk("hold_cnt6", out_cnt, 6);
    chk("hold_nout6", longint'(n_out), 6);
    chk("hold_drop0", drop, 0);

    // Randomized traffic with holds, reloads, clears and ReLU toggling.
    for (int k = 0; k < 9; k++) wsrc[k] = int'($urandom_range(255)) - 128;
    load_n(9);
    bias = 20'(int'($urandom_range(200000)) - 100000);
    for (int cyc = 0; cyc < 400; cyc++) begin
      hold    = ($urandom_range(4) == 0);
      relu_en = 1'($urandom_range(1));
      if ($urandom_range(3) != 0) begin rand_px(); drive_win(); end
      if (!ok_m) begin
        if ($urandom_range(1) == 1) begin
          w_in = 8'($urandom_range(255)); w_valid = 1'b1;
        end
      end else if ($urandom_range(59) == 0) begin
        w_in = 8'($urandom_range(255)); w_valid = 1'b1;
      end
      if ($urandom_range(149) == 0) w_clr = 1'b1;
      tick();
    end
    drain();
    chk("rand_cnt", out_cnt, longint'(n_out & 16'hFFFF));
    chk("rand_drop", drop, longint'(drop_m));

    // Asynchronous reset with windows in flight.
    for (int k = 0; k < 9; k++) wsrc[k] = 1;
    load_n(9);
    relu_en = 1'b0;
    for (int i = 0; i < 5; i++) begin rand_px(); drive_win(); tick(); end
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_cnt", out_cnt, 0);
    chk("arst_weights_ok", weights_ok, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) tick();
    chk("post_rst_ok", weights_ok, 0);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_drop", drop, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
